// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the inst/data SRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arbiter_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    // Which requester owns the single outstanding transaction
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_arbiter_pick.sv
// Grant selection between fetch and load/store requests (combinational pick).
// Latency: 0 cycles, result is used in the same IDLE cycle.
// Backpressure: none; the caller applies the pick only when it can accept a grant.
//
// Build option ARB_RR_EN: when defined, a simultaneous request goes to the
// side opposite the previous grant (1-bit pointer, reset favours data);
// when undefined, data always beats inst and no pointer register exists.
//
// Ports:
//   i_clk, i_rst, i_grant_en : pointer clock/reset/update (ARB_RR_EN only)
//   i_inst_req, i_data_req   : requests from the two sides
//   o_grant_vld, o_grant_own : some side is requesting / which side wins
module arb_pick
    import sram_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_grant_en,
`endif
    input  logic   i_inst_req,
    input  logic   i_data_req,
    output logic   o_grant_vld,
    output owner_t o_grant_own
);

    assign o_grant_vld = i_inst_req | i_data_req;

`ifdef ARB_RR_EN
    // Side that received the most recent grant. Reset to inst so the
    // first conflict after reset goes to data.
    owner_t r_last;

    always_comb begin
        o_grant_own = OWN_DATA;
        if (i_inst_req && i_data_req)
            o_grant_own = (r_last == OWN_DATA) ? OWN_INST : OWN_DATA;
        else if (i_inst_req)
            o_grant_own = OWN_INST;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_last <= OWN_INST;
        else if (i_grant_en && o_grant_vld)
            r_last <= o_grant_own;
    end
`else
    always_comb begin
        o_grant_own = i_data_req ? OWN_DATA : OWN_INST;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store.
// Latency: addr_ok same cycle as grant, mem_req next cycle, data_ok on mem_data_ok; >= 3 cycles/access.
// Backpressure: one outstanding transaction; no addr_ok outside IDLE, mem_* held until mem_addr_ok.
//
// Build option ARB_RR_EN: round-robin on simultaneous requests (see arb_pick);
// default is fixed data-over-inst priority.
//
// Ports:
//   clk, reset                     : clock, async active-high reset
//   inst_* (req/addr in; addr_ok/data_ok/rdata out)     : fetch side
//   data_* (req/wr/wstrb/addr/wdata in; addr_ok/data_ok/rdata out) : load/store side
//   mem_*  (req/wr/wstrb/addr/wdata out; addr_ok/data_ok/rdata in) : memory side
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    owner_t              r_owner;
    logic                r_wr;
    logic [STRB_W-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_grant_vld;
    owner_t              w_grant_own;
    logic                w_grant;

    arb_pick u_pick (
`ifdef ARB_RR_EN
        .i_clk       (clk),
        .i_rst       (reset),
        .i_grant_en  (r_state == ARB_IDLE),
`endif
        .i_inst_req  (inst_req),
        .i_data_req  (data_req),
        .o_grant_vld (w_grant_vld),
        .o_grant_own (w_grant_own)
    );

    assign w_grant = (r_state == ARB_IDLE) && w_grant_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ARB_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ARB_REQ;
                    // addr_ok is combinational from req; mask it while reset
                    // is held so every output reads 0 during reset.
                    if (w_grant_own == OWN_DATA)
                        data_addr_ok = !reset;
                    else
                        inst_addr_ok = !reset;
                end
            end
            ARB_REQ: begin
                mem_req = 1'b1;
                if (mem_addr_ok)
                    w_state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_data_ok) begin
                    w_state_nxt = ARB_IDLE;
                    if (r_owner == OWN_DATA)
                        data_data_ok = 1'b1;
                    else
                        inst_data_ok = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Payload latched at grant; the requester may change it afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_grant_own;
            if (w_grant_own == OWN_DATA) begin
                r_wr    <= data_wr;
                r_wstrb <= data_wstrb;
                r_addr  <= data_addr;
                r_wdata <= data_wdata;
            end else begin
                r_wr    <= 1'b0;
                r_wstrb <= '0;
                r_addr  <= inst_addr;
                r_wdata <= '0;
            end
        end
    end

    assign mem_wr    = r_wr;
    assign mem_wstrb = r_wstrb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Read data is only meaningful with data_ok; forcing 0 otherwise keeps
    // the outputs quiet during reset and on the non-owning side.
    assign inst_rdata = inst_data_ok ? mem_rdata : '0;
    assign data_rdata = data_data_ok ? mem_rdata : '0;

endmodule
